modn_counter_ctl: RTL and testbench

Parametrised, runtime-programmable mod-N counter. Successor to the fixed mod-N up counter.
- Adds a modulus sampled per run, up/down direction, free-run or one-shot mode, synchronous load, start/stop control, and wrap/done pulses.
- Used as a general timebase, divider and event sequencer, and cascadable via the `wrap` pulse.

---
 rtl/modn_ctr_pkg.sv | 14 +
 rtl/modn_prescaler.sv | 30 +++
 rtl/modn_counter_ctl.sv | 138 +++++++++++++
 tb/tb_modn_counter_ctl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/modn_ctr_pkg.sv
// Shared types and encodings for the programmable mod-N counter.
package modn_ctr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_FREE    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;

endpackage

// File: rtl/modn_prescaler.sv
// Divides en-qualified RUN cycles by (div+1); strike marks the cycle that becomes a count step.
module modn_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] div,
  output logic         strike
);

  logic [W-1:0] cnt_q, cnt_d;

  // >= rather than == so that lowering div mid-count cannot strand the counter.
  assign strike = tick && !clr && (cnt_q >= div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)         cnt_d = '0;
    else if (strike) cnt_d = '0;
    else if (tick)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/modn_counter_ctl.sv
// Runtime-programmable mod-N up/down counter with free-run/one-shot modes, load and wrap/done pulses.
// Optional prescaler on count steps is enabled by defining MODN_CTR_PRESCALE_EN.
module modn_counter_ctl #(
  parameter int WIDTH   = 4,
  parameter int N       = 10,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic               dir,
  input  logic [WIDTH-1:0]   mod_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
`ifdef MODN_CTR_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc_div,
`endif
  output logic [WIDTH-1:0]   out,
  output logic               wrap,
  output logic               done,
  output logic               busy
);

  import modn_ctr_pkg::*;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   mod_q, mod_d;
  logic               dir_q, dir_d;
  logic               mode_q, mode_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  // M-1 wraps to all ones when the modulus field is 0, which is exactly 2^WIDTH-1.
  logic [WIDTH-1:0]   last_cur, last_new, last_use;
  logic [WIDTH-1:0]   term_val, restart_val;
  logic               run_en, step;

  assign last_cur    = mod_q - 1'b1;
  assign last_new    = mod_n - 1'b1;
  assign term_val    = (dir_q == DIR_DOWN) ? '0 : last_cur;
  assign restart_val = (dir_q == DIR_DOWN) ? last_cur : '0;
  assign run_en      = (state_q == RUN) && en;

`ifdef MODN_CTR_PRESCALE_EN
  logic presc_clr;
  assign presc_clr = start | stop | load;

  modn_prescaler #(.W(PRESC_W)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr    (presc_clr),
    .tick   (run_en),
    .div    (presc_div),
    .strike (step)
  );
`else
  assign step = run_en;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    mod_d    = mod_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    last_use = last_cur;

    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      mod_d    = mod_n;
      dir_d    = dir;
      mode_d   = mode;
      last_use = last_new;
      out_d    = (dir == DIR_DOWN) ? last_new : '0;
      state_d  = RUN;
    end else if (step) begin
      if (out_q == term_val) begin
        if (mode_q == MODE_FREE) begin
          out_d  = restart_val;
          wrap_d = 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end else begin
        out_d = (dir_q == DIR_DOWN) ? out_q - 1'b1 : out_q + 1'b1;
      end
    end

    // A load replaces the terminal event entirely, including the one-shot exit.
    if (load) begin
      out_d = (load_val > last_use) ? last_use : load_val;
      if (done_d) state_d = state_q;
      wrap_d = 1'b0;
      done_d = 1'b0;
    end

    busy_d = (state_d == RUN);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      mod_q   <= WIDTH'(N);
      dir_q   <= DIR_UP;
      mode_q  <= MODE_FREE;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      mod_q   <= mod_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_modn_counter_ctl.sv
// Directed self-checking bench for modn_counter_ctl (WIDTH=4, N=10).
module tb_modn_counter_ctl;

  localparam int WIDTH   = 4;
  localparam int PRESC_W = 8;

  logic               clk = 1'b0;
  logic               rst, en, start, stop, mode, dir, load;
  logic [WIDTH-1:0]   mod_n, load_val;
  logic [PRESC_W-1:0] presc_div;
  logic [WIDTH-1:0]   out;
  logic               wrap, done, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  modn_counter_ctl #(.WIDTH(WIDTH), .N(10), .PRESC_W(PRESC_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .dir      (dir),
    .mod_n    (mod_n),
    .load     (load),
    .load_val (load_val),
`ifdef MODN_CTR_PRESCALE_EN
    .presc_div(presc_div),
`endif
    .out      (out),
    .wrap     (wrap),
    .done     (done),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int o, input int w, input int d, input int b);
    chk({tag, ".out"},  32'(out),  32'(o));
    chk({tag, ".wrap"}, 32'(wrap), 32'(w));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic do_start(input int m, input logic d, input logic md);
    mod_n = WIDTH'(m); dir = d; mode = md; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int exp;
    rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; dir = 1'b0;
    load = 1'b0; mod_n = '0; load_val = '0; presc_div = '0;
    step(); step();
    rst = 1'b0;
    chk_all("reset", 0, 0, 0, 0);

    // Load in IDLE clamps against the reset modulus N=10.
    load = 1'b1; load_val = 4'd12;
    step();
    load = 1'b0;
    chk_all("idle_load_clamp", 9, 0, 0, 0);
    rst = 1'b1; step(); rst = 1'b0;
    chk_all("reset2", 0, 0, 0, 0);

    // Free-run up, mod 10.
    en = 1'b1;
    do_start(10, 1'b0, 1'b0);
    chk_all("up_start", 0, 0, 0, 1);
    for (int k = 1; k <= 21; k++) begin
      step();
      exp = k % 10;
      chk_all("up_run", exp, (exp == 0) ? 1 : 0, 0, 1);
    end

    // Enable low freezes the count.
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all("en_low", 1, 0, 0, 1);
    end
    en = 1'b1;
    step();
    chk_all("en_back", 2, 0, 0, 1);

    // Loads mid-run.
    load = 1'b1; load_val = 4'd7; step(); load = 1'b0;
    chk_all("load7", 7, 0, 0, 1);
    step(); chk_all("load7_8", 8, 0, 0, 1);
    step(); chk_all("load7_9", 9, 0, 0, 1);
    step(); chk_all("load7_wrap", 0, 1, 0, 1);
    load = 1'b1; load_val = 4'd12; step();
    chk_all("load12", 9, 0, 0, 1);
    load_val = 4'd3; step(); load = 1'b0;
    chk_all("load_term", 3, 0, 0, 1);
    step(); chk_all("load_term_next", 4, 0, 0, 1);

    // Stop holds out, IDLE ignores en.
    stop = 1'b1; step(); stop = 1'b0;
    chk_all("stop", 4, 0, 0, 0);
    step(); chk_all("idle_hold", 4, 0, 0, 0);

    // Free-run down, mod 6; mid-run mod_n/dir changes ignored.
    do_start(6, 1'b1, 1'b0);
    chk_all("dn_start", 5, 0, 0, 1);
    mod_n = 4'd3; dir = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      step(); chk_all("dn_run", k, 0, 0, 1);
    end
    step(); chk_all("dn_wrap", 5, 1, 0, 1);
    step(); chk_all("dn_after", 4, 0, 0, 1);

    // Stop and start together: stop wins.
    stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
    chk_all("stop_start", 4, 0, 0, 0);

    // One-shot mod 4.
    do_start(4, 1'b0, 1'b1);
    chk_all("os_start", 0, 0, 0, 1);
    for (int k = 1; k <= 3; k++) begin
      step(); chk_all("os_run", k, 0, 0, 1);
    end
    step(); chk_all("os_done", 3, 0, 1, 0);
    step(); chk_all("os_hold", 3, 0, 0, 0);
    do_start(4, 1'b0, 1'b1);
    chk_all("os_restart", 0, 0, 0, 1);
    for (int k = 1; k <= 3; k++) step();
    chk_all("os_at_term", 3, 0, 0, 1);
    load = 1'b1; load_val = 4'd1; step(); load = 1'b0;
    chk_all("os_load_term", 1, 0, 0, 1);
    step(); step(); step();
    chk_all("os_done2", 3, 0, 1, 0);

    // Start while running re-latches the modulus.
    do_start(10, 1'b0, 1'b0);
    step(); step();
    chk_all("pre_restart", 2, 0, 0, 1);
    do_start(5, 1'b0, 1'b0);
    chk_all("restart", 0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      step();
      exp = k % 5;
      chk_all("restart_run", exp, (exp == 0) ? 1 : 0, 0, 1);
    end

    // Reset mid-run.
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk_all("rst_mid", 0, 0, 0, 0);

    // mod_n=0 means 16.
    do_start(0, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      step();
      exp = k % 16;
      chk_all("m16", exp, (exp == 0) ? 1 : 0, 0, 1);
    end

    // M=1 free-run: wrap on every enabled cycle.
    do_start(1, 1'b0, 1'b0);
    chk_all("m1_start", 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(); chk_all("m1_wrap", 0, 1, 0, 1);
    end
    en = 1'b0; step(); chk_all("m1_en_low", 0, 0, 0, 1);
    en = 1'b1;
    do_start(1, 1'b0, 1'b1);
    step(); chk_all("m1_oneshot", 0, 0, 1, 0);

    // Start with load clamps against the newly latched modulus.
    load = 1'b1; load_val = 4'd2;
    do_start(5, 1'b1, 1'b0);
    load = 1'b0;
    chk_all("start_load", 2, 0, 0, 1);
    step(); chk_all("start_load_dn", 1, 0, 0, 1);

`ifdef MODN_CTR_PRESCALE_EN
    presc_div = 8'd2;
    do_start(10, 1'b0, 1'b0);
    chk_all("presc_start", 0, 0, 0, 1);
    for (int k = 1; k <= 9; k++) begin
      step(); chk_all("presc_run", k / 3, 0, 0, 1);
    end
    presc_div = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
